// File: rtl/alu_op_sequencer.sv
// Request/response front end for the combinational ALU: runs single-pass ops directly
// and builds multi-bit shifts from repeated 1-bit ALU shift passes.
module alu_op_sequencer #(
   parameter int WIDTH = 32,
   parameter int OPW   = 7,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reqValid,
   output logic             reqReady,
   input  logic [OPW-1:0]   reqOp,
   input  logic [WIDTH-1:0] reqA,
   input  logic [WIDTH-1:0] reqB,
   output logic [WIDTH-1:0] aluA,
   output logic [WIDTH-1:0] aluB,
   output logic [OPW-1:0]   aluCtrl,
   input  logic [WIDTH-1:0] aluResult,
   input  logic [4:0]       aluFlags,
   output logic             respValid,
   input  logic             respReady,
   output logic [WIDTH-1:0] respData,
   output logic [4:0]       respFlags,
   output logic             respErr,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

   localparam logic [OPW-1:0] OP_SUB = OPW'(4);
   localparam logic [OPW-1:0] OP_SHL = OPW'(5);
   localparam logic [OPW-1:0] OP_SHR = OPW'(6);

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OPW-1:0]   alu_ctrl_q, alu_ctrl_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic [4:0]       resp_flags_q, resp_flags_d;
   logic             resp_err_q, resp_err_d;
   logic             resp_valid_q, resp_valid_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      resp_data_d  = resp_data_q;
      resp_flags_d = resp_flags_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         S_IDLE: begin
            if (reqValid && req_ready_q) begin
               if (reqOp <= OP_SUB) begin
                  alu_a_d    = reqA;
                  alu_b_d    = reqB;
                  alu_ctrl_d = reqOp;
                  state_d    = S_EXEC;
               end else if (reqOp == OP_SHL || reqOp == OP_SHR) begin
                  cnt_d = reqB[SHW-1:0];
                  if (reqB[SHW-1:0] != '0) begin
                     // The ALU A register doubles as the shift working register.
                     alu_a_d    = reqA;
                     alu_b_d    = '0;
                     alu_ctrl_d = reqOp;
                     state_d    = S_SHIFT;
                  end else begin
                     resp_data_d  = reqA;
                     resp_flags_d = '0;
                     resp_err_d   = 1'b0;
                     state_d      = S_DONE;
                  end
               end else begin
                  resp_data_d  = '0;
                  resp_flags_d = '0;
                  resp_err_d   = 1'b1;
                  state_d      = S_DONE;
               end
            end
         end
         S_EXEC: begin
            resp_data_d  = aluResult;
            resp_flags_d = aluFlags;
            resp_err_d   = 1'b0;
            state_d      = S_DONE;
         end
         S_SHIFT: begin
            alu_a_d = aluResult;
            cnt_d   = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               resp_data_d  = aluResult;
               resp_flags_d = aluFlags;
               resp_err_d   = 1'b0;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            if (respReady) begin
               resp_err_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Handshake/status outputs are registered views of the next state.
      req_ready_d  = (state_d == S_IDLE);
      busy_d       = (state_d != S_IDLE);
      resp_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         resp_data_q  <= '0;
         resp_flags_q <= '0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         resp_data_q  <= resp_data_d;
         resp_flags_q <= resp_flags_d;
         resp_err_q   <= resp_err_d;
         resp_valid_q <= resp_valid_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign reqReady  = req_ready_q;
   assign aluA      = alu_a_q;
   assign aluB      = alu_b_q;
   assign aluCtrl   = alu_ctrl_q;
   assign respValid = resp_valid_q;
   assign respData  = resp_data_q;
   assign respFlags = resp_flags_q;
   assign respErr   = resp_err_q;
   assign busy      = busy_q;

endmodule
